serial_add_seq: RTL and testbench

Bit-serial sequencer that drives the team's 3-bit-input full-adder stage. It sits both upstream and downstream of that stage:
- Upstream: on a start request it latches two WIDTH-bit operands and a carry-in, then presents one {a,b,carry} triple per clock on fa_din.
- Downstream: it captures fa_sum/fa_cout each cycle, registers the carry, and assembles the WIDTH-bit result.

The result, with carry-out, is reported under a start/busy/done handshake.

---
 rtl/serial_add_seq.sv | 77 +++++++
 tb/tb_serial_add_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: feeds one {a,b,carry} triple per clock to an
// external full-adder stage and assembles the WIDTH-bit sum plus carry-out.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [2:0]       fa_din,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Outputs toward the adder stage come only from registers, so there is no
  // combinational loop through fa_sum/fa_cout.
  assign busy   = (state == RUN);
  assign fa_din = (state == RUN) ? {a_sr[0], b_sr[0], carry} : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr  <= a_in;
          b_sr  <= b_in;
          carry <= cin_in;
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
        carry <= fa_cout;
        cnt   <= cnt + 1'b1;
        // Final bit: publish the completed word directly from the live sum bit.
        if (cnt == LAST) begin
          sum_out  <= {fa_sum, s_sr[WIDTH-1:1]};
          cout_out <= fa_cout;
          done     <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and randomized checks of serial_add_seq (WIDTH=8 and WIDTH=4)
// with a behavioural full-adder stage closing the loop.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic [2:0] fa_din8;
  logic       fa_sum8, fa_cout8, busy8, done8, cout8;
  logic [7:0] sum8;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic [2:0] fa_din4;
  logic       fa_sum4, fa_cout4, busy4, done4, cout4;
  logic [3:0] sum4;

  // Full-adder stage
  assign fa_sum8  = ^fa_din8;
  assign fa_cout8 = (fa_din8[2] & fa_din8[1]) | (fa_din8[2] & fa_din8[0]) | (fa_din8[1] & fa_din8[0]);
  assign fa_sum4  = ^fa_din4;
  assign fa_cout4 = (fa_din4[2] & fa_din4[1]) | (fa_din4[2] & fa_din4[0]) | (fa_din4[1] & fa_din4[0]);

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .fa_din(fa_din8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin_in(cin4),
    .fa_din(fa_din4), .fa_sum(fa_sum4), .fa_cout(fa_cout4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated WIDTH=8 addition with latency, busy-length and pulse-width checks.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] ref_sum;
    int k, nb;
    bit seen;
    ref_sum = 9'(a) + 9'(b) + 9'(c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    nb = busy8 ? 1 : 0;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (done8) seen = 1;
      else if (busy8) nb++;
    end
    chk({tag, "_done_edge"}, 64'(k), 64'd8);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd8);
    chk({tag, "_result"}, 64'({cout8, sum8}), 64'(ref_sum));
    tick();
    chk({tag, "_done_width"}, 64'(done8), 64'd0);
    $display("run8 %s: %02h + %02h + %0d -> cout=%0d sum=%02h", tag, a, b, c, cout8, sum8);
  endtask

  initial begin
    int k, ndone, first_done, second_done;
    logic [7:0] seen_sum;
    logic [4:0] ref4;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'({cout8, sum8}), 64'd0);
    chk("rst_fa_din", 64'(fa_din8), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1 and 2
    run8("t1", 8'h5A, 8'h3C, 1'b0);
    run8("t2a", 8'hFF, 8'h01, 1'b0);
    run8("t2b", 8'hFF, 8'hFF, 1'b1);

    // 3: start while busy is ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'hAA; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; seen_sum = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) begin ndone++; seen_sum = sum8; end
    end
    chk("t3_done_count", 64'(ndone), 64'd1);
    chk("t3_sum", 64'(seen_sum), 64'h30);
    $display("t3: done pulses=%0d sum=%02h", ndone, seen_sum);

    // 4: start held high, second operands presented on the done cycle
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    k = 0; first_done = -1; second_done = -1;
    while (second_done < 0 && k < 40) begin
      tick();
      k++;
      if (done8) begin
        if (first_done < 0) begin
          first_done = k;
          chk("t4_first", 64'({cout8, sum8}), 64'h002);
          a8 = 8'h7F; b8 = 8'h01;
        end else begin
          second_done = k;
          start8 = 1'b0;
          chk("t4_second", 64'({cout8, sum8}), 64'h080);
        end
      end else if (first_done > 0 && k == first_done + 4) begin
        chk("t4_hold", 64'({cout8, sum8}), 64'h002);
      end
    end
    start8 = 1'b0;
    chk("t4_spacing", 64'(second_done - first_done), 64'd9);
    $display("t4: done at +%0d and +%0d", first_done, second_done);
    tick(); tick();

    // 5: asynchronous reset mid-addition
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy8), 64'd0);
    chk("t5_done", 64'(done8), 64'd0);
    chk("t5_out", 64'({cout8, sum8}), 64'd0);
    chk("t5_fa_din", 64'(fa_din8), 64'd0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    $display("t5: reset abort, done pulses after=%0d", ndone);
    run8("t5b", 8'h03, 8'h04, 1'b0);

    // 6: WIDTH=4 random
    for (int n = 0; n < 500; n++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      ref4 = 5'(a4) + 5'(b4) + 5'(cin4);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      k = 0;
      while (!done4 && k < 20) begin
        tick();
        k++;
        if (!busy4) chk("t6_idle_fa_din", 64'(fa_din4), 64'd0);
      end
      chk("t6_done_edge", 64'(k), 64'd4);
      chk("t6_result", 64'({cout4, sum4}), 64'(ref4));
      $display("t6 #%0d: %01h + %01h + %0d -> %02h", n, a4, b4, cin4, {cout4, sum4});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
